// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, stall hold, beq/bne resolution on the ALU zero flag, post-redirect flush.
// Optional: define PC_SEQ_JUMP_EN to redirect on J-type (opcode 000010) directly from RUN.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        instr_valid,
   input  logic [31:0] ext_offset,
   input  logic [25:0] jump_target,
   input  logic        zero,
   input  logic        zero_valid,
   input  logic        stall,
   output logic [31:0] pc,
   output logic        fetch_en,
   output logic        flush,
   output logic        branch_taken,
   output logic        busy
);

   localparam int unsigned PC_W  = 32;
   localparam int unsigned OP_W  = 6;
   localparam int unsigned CNT_W = 4;

   localparam logic [OP_W-1:0]  OP_BEQ     = OP_W'(6'b000100);
   localparam logic [OP_W-1:0]  OP_BNE     = OP_W'(6'b000101);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_RESOLVE = 2'd2,
      S_FLUSH   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bne_q, bne_d;
   logic               taken_q, taken_d;
   logic               is_branch;
   logic               is_jump;
   logic               br_taken;

   assign is_branch = instr_valid & ((opcode == OP_BEQ) | (opcode == OP_BNE));
   assign br_taken  = bne_q ? ~zero : zero;

`ifdef PC_SEQ_JUMP_EN
   localparam logic [OP_W-1:0] OP_J = OP_W'(6'b000010);
   assign is_jump = instr_valid & (opcode == OP_J);
`else
   logic unused_jump_target;
   assign is_jump            = 1'b0;
   assign unused_jump_target = ^jump_target;
`endif

   // State, PC, flush counter and latched branch type.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         bne_q   <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         bne_q   <= bne_d;
         taken_q <= taken_d;
      end
   end

   // Next-state and PC update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      bne_d   = bne_q;
      taken_d = 1'b0;
      unique case (state_q)
         S_IDLE: state_d = S_RUN;
         S_RUN: begin
            if (stall) begin
               state_d = S_RUN;
            end else if (is_branch) begin
               bne_d   = (opcode == OP_BNE);
               state_d = S_RESOLVE;
            end else if (is_jump) begin
               pc_d    = {pc_q[PC_W-1:26], jump_target};
               cnt_d   = FLUSH_LOAD;
               taken_d = 1'b1;
               state_d = S_FLUSH;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         S_RESOLVE: begin
            if (zero_valid) begin
               if (br_taken) begin
                  pc_d    = pc_q + ext_offset - PC_W'(1);
                  cnt_d   = FLUSH_LOAD;
                  taken_d = 1'b1;
                  state_d = S_FLUSH;
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = S_RUN;
               end
            end
         end
         S_FLUSH: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pc           = pc_q;
   assign fetch_en     = (state_q == S_RUN) & ~stall;
   assign flush        = (state_q == S_FLUSH);
   assign busy         = (state_q != S_RUN);
   assign branch_taken = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: spec-level model compared every cycle plus hand-computed literal checks.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h10;
   localparam int          FC     = 2;

   localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_FLUSH = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = '0;
   logic        instr_valid = 1'b0;
   logic [31:0] ext_offset = '0;
   logic [25:0] jump_target = '0;
   logic        zero = 1'b0;
   logic        zero_valid = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] pc;
   logic        fetch_en, flush, branch_taken, busy;

   int n_vec = 0;
   int n_bad = 0;

   // Spec-level model: phase of operation, PC, flush cycles left, pending branch kind.
   int          m_mode = M_IDLE;
   logic [31:0] m_pc = RST_PC;
   int          m_left = 0;
   bit          m_bne = 1'b0;

   pc_sequencer #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
      .ext_offset(ext_offset), .jump_target(jump_target), .zero(zero),
      .zero_valid(zero_valid), .stall(stall), .pc(pc), .fetch_en(fetch_en),
      .flush(flush), .branch_taken(branch_taken), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare outputs against the model at the negedge, then advance the model across the next posedge.
   task automatic cyc();
      bit taken;
      @(negedge clk);
      if (reset) begin
         m_mode = M_IDLE; m_pc = RST_PC; m_left = 0; m_bne = 1'b0;
      end
      chk("m_pc",       pc,                   m_pc);
      chk("m_fetch_en", 32'(fetch_en),        32'((m_mode == M_RUN) && !stall));
      chk("m_flush",    32'(flush),           32'(m_mode == M_FLUSH));
      chk("m_busy",     32'(busy),            32'(m_mode != M_RUN));
      chk("m_taken",    32'(branch_taken),    32'((m_mode == M_FLUSH) && (m_left == FC)));
      if (!reset) begin
         case (m_mode)
            M_IDLE: m_mode = M_RUN;
            M_RUN: begin
               if (stall) begin
                  m_mode = M_RUN;
               end else if (instr_valid && (opcode == 6'd4 || opcode == 6'd5)) begin
                  m_bne  = (opcode == 6'd5);
                  m_mode = M_WAIT;
`ifdef PC_SEQ_JUMP_EN
               end else if (instr_valid && opcode == 6'd2) begin
                  m_pc   = {m_pc[31:26], jump_target};
                  m_left = FC;
                  m_mode = M_FLUSH;
`endif
               end else begin
                  m_pc = m_pc + 32'd1;
               end
            end
            M_WAIT: begin
               if (zero_valid) begin
                  taken = m_bne ? !zero : zero;
                  if (taken) begin
                     m_pc   = m_pc + ext_offset - 32'd1;
                     m_left = FC;
                     m_mode = M_FLUSH;
                  end else begin
                     m_pc   = m_pc + 32'd1;
                     m_mode = M_RUN;
                  end
               end
            end
            default: begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = M_RUN;
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      instr_valid = 1'b0; opcode = '0; zero_valid = 1'b0; zero = 1'b0; stall = 1'b0;
   endtask

   task automatic seq_n(input int n);
      for (int i = 0; i < n; i++) begin
         instr_valid = 1'b1; opcode = 6'd0;
         cyc();
      end
      quiet();
   endtask

   // Branch decoded in RUN, resolved in the first RESOLVE cycle.
   task automatic branch(input logic [5:0] op, input logic [31:0] off, input logic z);
      instr_valid = 1'b1; opcode = op; ext_offset = off;
      cyc();
      quiet();
      zero_valid = 1'b1; zero = z;
      cyc();
      quiet();
   endtask

   initial begin
      // Reset behaviour
      for (int i = 0; i < 3; i++) cyc();
      reset = 1'b0;
      #1;
      chk("idle_pc", pc, 32'h10);
      chk("idle_busy", 32'(busy), 32'd1);
      chk("idle_fetch", 32'(fetch_en), 32'd0);
      cyc();
      chk("run_fetch", 32'(fetch_en), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);
      seq_n(4);
      chk("seq4_pc", pc, 32'h14);

      // beq taken, zero arrives two cycles after decode
      seq_n(12);
      chk("pre_beq_pc", pc, 32'h20);
      instr_valid = 1'b1; opcode = 6'd4; ext_offset = 32'h8;
      cyc();
      quiet();
      cyc();
      chk("resolve_hold_pc", pc, 32'h20);
      chk("resolve_busy", 32'(busy), 32'd1);
      zero_valid = 1'b1; zero = 1'b1;
      cyc();
      quiet();
      chk("beq_target", pc, 32'h27);
      chk("beq_pulse", 32'(branch_taken), 32'd1);
      chk("beq_flush1", 32'(flush), 32'd1);
      cyc();
      chk("beq_pulse_gone", 32'(branch_taken), 32'd0);
      chk("beq_flush2", 32'(flush), 32'd1);
      cyc();
      chk("post_flush_fetch", 32'(fetch_en), 32'd1);

      // bne not taken then taken, negative offset
      seq_n(25);
      chk("pre_bne_pc", pc, 32'h40);
      branch(6'd5, 32'hFFFF_FFFC, 1'b1);
      chk("bne_nt_pc", pc, 32'h41);
      chk("bne_nt_flush", 32'(flush), 32'd0);
      chk("bne_nt_taken", 32'(branch_taken), 32'd0);
      branch(6'd4, 32'h0, 1'b1);
      chk("back_to_40", pc, 32'h40);
      cyc(); cyc();
      branch(6'd5, 32'hFFFF_FFFC, 1'b0);
      chk("bne_t_pc", pc, 32'h3B);
      cyc(); cyc();

      // Stall against a valid beq
      instr_valid = 1'b1; opcode = 6'd4; ext_offset = 32'h5; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_pc", pc, 32'h3B);
         chk("stall_busy", 32'(busy), 32'd0);
      end
      stall = 1'b0;
      cyc();
      chk("after_stall_busy", 32'(busy), 32'd1);
      quiet();
      stall = 1'b1;
      cyc();
      stall = 1'b0; zero_valid = 1'b1; zero = 1'b0;
      cyc();
      quiet();
      chk("beq_nt_pc", pc, 32'h3C);

      // Wrap from 32'hFFFF_FFFF
      branch(6'd4, 32'hFFFF_FFC4, 1'b1);
      chk("to_max_pc", pc, 32'hFFFF_FFFF);
      cyc(); cyc();
      seq_n(1);
      chk("wrap_pc", pc, 32'h0);

      // Jump
      branch(6'd4, 32'hA000_0006, 1'b1);
      chk("pre_j_pc", pc, 32'hA000_0005);
      cyc(); cyc();
      instr_valid = 1'b1; opcode = 6'd2; jump_target = 26'h123;
      cyc();
      quiet();
`ifdef PC_SEQ_JUMP_EN
      chk("j_pc", pc, 32'hA000_0123);
      chk("j_flush", 32'(flush), 32'd1);
      chk("j_pulse", 32'(branch_taken), 32'd1);
`else
      chk("j_seq_pc", pc, 32'hA000_0006);
      chk("j_seq_flush", 32'(flush), 32'd0);
`endif
      cyc(); cyc();

      // Reset while waiting for zero_valid
      instr_valid = 1'b1; opcode = 6'd4; ext_offset = 32'h40;
      cyc();
      quiet();
      cyc();
      chk("mid_resolve_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_reset_pc", pc, 32'h10);
      chk("mid_reset_taken", 32'(branch_taken), 32'd0);
      zero_valid = 1'b1; zero = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("post_reset_pc", pc, 32'h13);
      chk("post_reset_taken", 32'(branch_taken), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
